// File: rtl/dpe_feeder.sv
// dpe_feeder: streams weight rows and compute vectors into a grid of 4-lane DPE groups.
// Weight rows are loaded with a per-group skew of k cycles for group k. Compute
// vectors go to every group in the same cycle.
// Optional build macro DPE_FEEDER_STATS_EN adds the o_stall_cycles counter.
module dpe_feeder #(
    parameter int IDATAW   = 8,
    parameter int LANES    = 40,
    parameter int BATCH    = 1,
    parameter int NUM_DSPS = LANES / 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [15:0]              i_num_vecs,
    input  logic                     i_wt_valid,
    output logic                     o_wt_ready,
    input  logic signed [IDATAW-1:0] i_wt_data [0:LANES-1],
    input  logic                     i_vec_valid,
    output logic                     o_vec_ready,
    input  logic signed [IDATAW-1:0] i_vec_data [0:LANES-1],
    output logic signed [IDATAW-1:0] o_dpe_data [0:NUM_DSPS-1][0:3],
    output logic                     o_dpe_valid,
    output logic                     o_dpe_load,
    output logic                     o_busy,
    output logic                     o_done
`ifdef DPE_FEEDER_STATS_EN
    ,
    output logic [31:0]              o_stall_cycles
`endif
);

    // Skew lines are packed in triangular form: group k owns k+1 stages,
    // and its last stage drives the group output.
    localparam int NSTAGES  = NUM_DSPS * (NUM_DSPS + 1) / 2;
    localparam int SKEW_LEN = NUM_DSPS - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StSkew, StCompute} state_e;

    state_e      r_state;
    logic [15:0] r_num_vecs;
    logic [15:0] r_wt_cnt;
    logic [15:0] r_vec_cnt;
    logic [15:0] r_skew_cnt;
    logic        r_wt_ready;
    logic        r_vec_ready;
    logic        r_done;
    logic        r_dpe_valid;
    logic        r_dpe_load;
    logic signed [IDATAW-1:0] r_line [0:NSTAGES-1][0:3];

    logic w_wt_hs;
    logic w_vec_hs;

    assign w_wt_hs  = i_wt_valid && r_wt_ready;
    assign w_vec_hs = i_vec_valid && r_vec_ready;

    // Job sequencing: load weights, flush the skew lines, then stream vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_num_vecs  <= '0;
            r_wt_cnt    <= '0;
            r_vec_cnt   <= '0;
            r_skew_cnt  <= '0;
            r_wt_ready  <= 1'b0;
            r_vec_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_vecs <= i_num_vecs;
                        r_wt_cnt   <= '0;
                        r_vec_cnt  <= '0;
                        r_skew_cnt <= '0;
                        r_wt_ready <= 1'b1;
                        r_state    <= StLoad;
                    end
                end
                StLoad: begin
                    if (w_wt_hs) begin
                        if (r_wt_cnt == 16'(BATCH - 1)) begin
                            r_wt_ready <= 1'b0;
                            if (NUM_DSPS > 1) begin
                                r_state <= StSkew;
                            end else if (r_num_vecs == 16'd0) begin
                                r_done  <= 1'b1;
                                r_state <= StIdle;
                            end else begin
                                r_vec_ready <= 1'b1;
                                r_state     <= StCompute;
                            end
                        end else begin
                            r_wt_cnt <= r_wt_cnt + 16'd1;
                        end
                    end
                end
                StSkew: begin
                    if (r_skew_cnt == 16'(SKEW_LEN - 1)) begin
                        if (r_num_vecs == 16'd0) begin
                            r_done  <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_vec_ready <= 1'b1;
                            r_state     <= StCompute;
                        end
                    end else begin
                        r_skew_cnt <= r_skew_cnt + 16'd1;
                    end
                end
                StCompute: begin
                    if (w_vec_hs) begin
                        // Compare against count-1 so 65535 finishes without wrapping.
                        if (r_vec_cnt == r_num_vecs - 16'd1) begin
                            r_vec_ready <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_vec_cnt <= r_vec_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // DPE drive: skewed weight lines, with compute vectors written straight into output stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dpe_valid <= 1'b0;
            r_dpe_load  <= 1'b0;
            for (int s = 0; s < NSTAGES; s++) begin
                for (int j = 0; j < 4; j++) begin
                    r_line[s][j] <= '0;
                end
            end
        end else begin
            r_dpe_valid <= w_wt_hs || w_vec_hs;
            r_dpe_load  <= w_wt_hs;
            for (int k = 0; k < NUM_DSPS; k++) begin
                for (int j = 0; j < 4; j++) begin
                    r_line[k*(k+1)/2][j] <= w_wt_hs ? i_wt_data[4*k+j] : '0;
                    for (int d = 1; d <= k; d++) begin
                        r_line[k*(k+1)/2+d][j] <= r_line[k*(k+1)/2+d-1][j];
                    end
                    // Lines are empty in COMPUTE, so the vector never collides with load data.
                    if (w_vec_hs) begin
                        r_line[k*(k+1)/2+k][j] <= i_vec_data[4*k+j];
                    end
                end
            end
        end
    end

    // Each group output is the tail of its skew line.
    always_comb begin
        for (int k = 0; k < NUM_DSPS; k++) begin
            for (int j = 0; j < 4; j++) begin
                o_dpe_data[k][j] = r_line[k*(k+1)/2+k][j];
            end
        end
    end

    assign o_wt_ready  = r_wt_ready;
    assign o_vec_ready = r_vec_ready;
    assign o_dpe_valid = r_dpe_valid;
    assign o_dpe_load  = r_dpe_load;
    assign o_done      = r_done;
    assign o_busy      = (r_state != StIdle);

`ifdef DPE_FEEDER_STATS_EN
    logic [31:0] r_stall_cnt;

    // Counts compute cycles where the feeder was ready but upstream had no vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == StCompute && r_vec_ready && !i_vec_valid &&
                     r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dpe_feeder.sv
// Scoreboard bench for dpe_feeder (LANES=8, NUM_DSPS=2, BATCH=2).
// Drivers record per-cycle expectations; a negedge monitor compares every cycle.
module tb_dpe_feeder;

    localparam int IDATAW   = 8;
    localparam int LANES    = 8;
    localparam int BATCH    = 2;
    localparam int NUM_DSPS = 2;

    typedef logic signed [IDATAW-1:0] row_t [0:LANES-1];

    logic                     clk;
    logic                     rst;
    logic                     i_start;
    logic [15:0]              i_num_vecs;
    logic                     i_wt_valid;
    logic                     o_wt_ready;
    logic signed [IDATAW-1:0] i_wt_data [0:LANES-1];
    logic                     i_vec_valid;
    logic                     o_vec_ready;
    logic signed [IDATAW-1:0] i_vec_data [0:LANES-1];
    logic signed [IDATAW-1:0] o_dpe_data [0:NUM_DSPS-1][0:3];
    logic                     o_dpe_valid;
    logic                     o_dpe_load;
    logic                     o_busy;
    logic                     o_done;
`ifdef DPE_FEEDER_STATS_EN
    logic [31:0]              o_stall_cycles;
`endif

    dpe_feeder #(
        .IDATAW  (IDATAW),
        .LANES   (LANES),
        .BATCH   (BATCH),
        .NUM_DSPS(NUM_DSPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_num_vecs (i_num_vecs),
        .i_wt_valid (i_wt_valid),
        .o_wt_ready (o_wt_ready),
        .i_wt_data  (i_wt_data),
        .i_vec_valid(i_vec_valid),
        .o_vec_ready(o_vec_ready),
        .i_vec_data (i_vec_data),
        .o_dpe_data (o_dpe_data),
        .o_dpe_valid(o_dpe_valid),
        .o_dpe_load (o_dpe_load),
        .o_busy     (o_busy),
        .o_done     (o_done)
`ifdef DPE_FEEDER_STATS_EN
        ,
        .o_stall_cycles(o_stall_cycles)
`endif
    );

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int cur_nv;
    int wt_cnt;
    int vec_cnt;

    // Scoreboard, keyed by output cycle (data keyed by cycle*NUM_DSPS+group).
    bit          exp_v [int];
    bit          exp_l [int];
    bit          exp_d [int];
    logic [31:0] exp_g [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] pk(input row_t r, input int b);
        return {r[b], r[b+1], r[b+2], r[b+3]};
    endfunction

    function automatic bit ev(input int c);
        return exp_v.exists(c) ? exp_v[c] : 1'b0;
    endfunction

    function automatic bit el(input int c);
        return exp_l.exists(c) ? exp_l[c] : 1'b0;
    endfunction

    function automatic bit ed(input int c);
        return exp_d.exists(c) ? exp_d[c] : 1'b0;
    endfunction

    function automatic logic [31:0] eg(input int key);
        return exp_g.exists(key) ? exp_g[key] : 32'h0;
    endfunction

    // Drop every expectation after cycle c (a reset cancels scheduled beats).
    function automatic void purge(input int c);
        int ks[$];
        ks = {};
        foreach (exp_v[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_v.delete(ks[i]);
        ks = {};
        foreach (exp_l[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_l.delete(ks[i]);
        ks = {};
        foreach (exp_d[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_d.delete(ks[i]);
        ks = {};
        foreach (exp_g[k]) if (k >= (c + 1) * NUM_DSPS) ks.push_back(k);
        foreach (ks[i]) exp_g.delete(ks[i]);
    endfunction

    // Monitor: every cycle the DPE drive must equal the scoreboard (zero where nothing is due).
    always @(negedge clk) begin
        if (mon_en) begin
            check("dpe_valid", {31'b0, o_dpe_valid}, {31'b0, ev(cyc)});
            check("dpe_load", {31'b0, o_dpe_load}, {31'b0, el(cyc)});
            check("done", {31'b0, o_done}, {31'b0, ed(cyc)});
            for (int k = 0; k < NUM_DSPS; k++) begin
                check($sformatf("group%0d", k),
                      {o_dpe_data[k][0], o_dpe_data[k][1], o_dpe_data[k][2], o_dpe_data[k][3]},
                      eg(cyc * NUM_DSPS + k));
            end
            check("ready_excl", {31'b0, o_wt_ready && o_vec_ready}, 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        i_start    = 1'b1;
        i_num_vecs = 16'(n);
        cur_nv     = n;
        wt_cnt     = 0;
        vec_cnt    = 0;
        step();
        i_start    = 1'b0;
    endtask

    task automatic send_wt(input row_t r);
        bit got;
        got        = 1'b0;
        i_wt_valid = 1'b1;
        i_wt_data  = r;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (o_wt_ready) begin
                got = 1'b1;
                exp_v[cyc+1] = 1'b1;
                exp_l[cyc+1] = 1'b1;
                for (int k = 0; k < NUM_DSPS; k++) begin
                    exp_g[(cyc + 1 + k) * NUM_DSPS + k] = pk(r, 4 * k);
                end
                wt_cnt++;
                // SKEW lasts one cycle, done follows it.
                if (wt_cnt == BATCH && cur_nv == 0) exp_d[cyc+2] = 1'b1;
            end
            step();
        end
        i_wt_valid = 1'b0;
        if (!got) check("wt_handshake_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_vec(input row_t v);
        bit got;
        got         = 1'b0;
        i_vec_valid = 1'b1;
        i_vec_data  = v;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (o_vec_ready) begin
                got = 1'b1;
                exp_v[cyc+1] = 1'b1;
                for (int k = 0; k < NUM_DSPS; k++) begin
                    exp_g[(cyc + 1) * NUM_DSPS + k] = pk(v, 4 * k);
                end
                vec_cnt++;
                if (vec_cnt == cur_nv) exp_d[cyc+1] = 1'b1;
            end
            step();
        end
        i_vec_valid = 1'b0;
        if (!got) check("vec_handshake_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge clk);
            if (!o_busy) idle = 1'b1;
            step();
        end
        if (!idle) check("idle_timeout", 32'h0, 32'h1);
    endtask

    row_t w0, w1, w2, w3, v0, v1, v2;
    bit   seen;

    initial begin
        w0 = '{8'sd1, -8'sd2, 8'sd3, -8'sd4, 8'sd5, -8'sd6, 8'sd7, -8'sd8};
        w1 = '{8'sh11, 8'sh22, 8'sh33, 8'sh44, 8'sh55, 8'sh66, 8'sh77, -8'sd128};
        w2 = '{-8'sd1, 8'sd9, 8'sd10, 8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15};
        w3 = '{8'sh7f, 8'sh01, 8'sh02, 8'sh03, 8'sh04, 8'sh05, 8'sh06, 8'sh07};
        v0 = '{8'sh0a, 8'sh0b, 8'sh0c, 8'sh0d, 8'sh0e, 8'sh0f, 8'sh10, 8'sh12};
        v1 = '{-8'sd5, -8'sd6, -8'sd7, -8'sd8, 8'sd20, 8'sd21, 8'sd22, 8'sd23};
        v2 = '{8'sh5a, 8'sha5, 8'sh3c, 8'shc3, 8'sh69, 8'sh96, 8'sh18, 8'sh81};

        rst         = 1'b1;
        i_start     = 1'b0;
        i_num_vecs  = 16'd0;
        i_wt_valid  = 1'b0;
        i_vec_valid = 1'b0;
        i_wt_data   = w0;
        i_vec_data  = v0;

        // Reset state.
        step();
        mon_en = 1'b1;
        step();
        @(negedge clk);
        check("rst_busy", {31'b0, o_busy}, 32'h0);
        check("rst_wt_ready", {31'b0, o_wt_ready}, 32'h0);
        check("rst_vec_ready", {31'b0, o_vec_ready}, 32'h0);
        step();
        rst = 1'b0;
        step();

        // One vector after a back-to-back two-row load.
        start_job(1);
        send_wt(w0);
        send_wt(w1);
        @(negedge clk);
        check("skew_vec_ready", {31'b0, o_vec_ready}, 32'h0);
        check("skew_wt_ready", {31'b0, o_wt_ready}, 32'h0);
        check("skew_busy", {31'b0, o_busy}, 32'h1);
        send_vec(v0);
        wait_idle();

        // Zero vectors: compute phase skipped entirely.
        start_job(0);
        send_wt(w2);
        send_wt(w3);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_vec_ready) seen = 1'b1;
            step();
        end
        check("zero_vecs_no_ready", {31'b0, seen}, 32'h0);
        check("zero_vecs_idle", {31'b0, o_busy}, 32'h0);

        // Three-cycle upstream gap mid-compute gives three bubbles.
        start_job(3);
        send_wt(w1);
        send_wt(w0);
        send_vec(v0);
        repeat (3) step();
        send_vec(v1);
        send_vec(v2);
        wait_idle();
`ifdef DPE_FEEDER_STATS_EN
        check("stall_cycles", o_stall_cycles, 32'd3);
`endif

        // Reset during SKEW aborts the job; the next start still works.
        start_job(2);
        send_wt(w2);
        send_wt(w3);
        purge(cyc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, o_busy}, 32'h0);
        check("abort_wt_ready", {31'b0, o_wt_ready}, 32'h0);
        check("abort_vec_ready", {31'b0, o_vec_ready}, 32'h0);
        step();
        start_job(1);
        send_wt(w3);
        send_wt(w2);
        send_vec(v2);
        wait_idle();

        // A start pulse during COMPUTE is ignored.
        start_job(2);
        send_wt(w0);
        send_wt(w1);
        send_vec(v1);
        i_start    = 1'b1;
        i_num_vecs = 16'd5;
        step();
        i_start    = 1'b0;
        send_vec(v0);
        wait_idle();
        repeat (4) step();
        @(negedge clk);
        check("ignored_start_idle", {31'b0, o_busy}, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
